// File: rtl/dram_cmd_responder_if.sv
// rtl/dram_cmd_responder_if.sv - controller-to-DRAM-device command, select and serial data signals
interface dram_cmd_responder_if #(
  parameter int NUM_OF_BANKS = 8,
  parameter int NUM_OF_ROWS  = 128,
  parameter int NUM_OF_COLS  = 8
) ();
  logic                    cmd_req;
  logic [1:0]              cmd;
  logic [NUM_OF_BANKS-1:0] bank_sel;
  logic [NUM_OF_ROWS-1:0]  row_sel;
  logic [NUM_OF_COLS-1:0]  col_sel;
  logic                    bank_rw;
  logic                    data_in;
  logic                    data_out;
  logic                    data_oe;
  logic                    cmd_ack;
  logic                    busy;
  logic                    err;
  logic [1:0]              err_code;
  logic                    refresh_miss;

  modport master (
    output cmd_req, cmd, bank_sel, row_sel, col_sel, bank_rw, data_in,
    input  data_out, data_oe, cmd_ack, busy, err, err_code, refresh_miss
  );

  modport slave (
    input  cmd_req, cmd, bank_sel, row_sel, col_sel, bank_rw, data_in,
    output data_out, data_oe, cmd_ack, busy, err, err_code, refresh_miss
  );
endinterface

// File: rtl/dram_cmd_responder.sv
// rtl/dram_cmd_responder.sv - device-side DRAM array model answering controller commands
// Optional refresh watchdog enabled by defining DRAM_RESP_REFRESH_WDT_EN.
module dram_cmd_responder #(
  parameter int NUM_OF_BANKS = 8,
  parameter int NUM_OF_ROWS  = 128,
  parameter int NUM_OF_COLS  = 8,
  parameter int DATA_WIDTH   = 8,
  parameter int T_RCD        = 3,
  parameter int T_CL         = 2,
  parameter int T_RP         = 3,
  parameter int T_RFC        = 8,
  parameter int T_REFI       = 1024
) (
  input logic                 i_clk,
  input logic                 i_rst_b,
  dram_cmd_responder_if.slave bus
);
  localparam int BW    = (NUM_OF_BANKS > 1) ? $clog2(NUM_OF_BANKS) : 1;
  localparam int RWID  = (NUM_OF_ROWS > 1) ? $clog2(NUM_OF_ROWS) : 1;
  localparam int CLW   = (NUM_OF_COLS > 1) ? $clog2(NUM_OF_COLS) : 1;
  localparam int KW    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int T_M1  = (T_RCD > T_CL) ? T_RCD : T_CL;
  localparam int T_M2  = (T_RP > T_RFC) ? T_RP : T_RFC;
  localparam int T_MAX = (T_M1 > T_M2) ? T_M1 : T_M2;
  localparam int CW    = $clog2(T_MAX + 1);

  localparam logic [1:0] C_REF = 2'd0;
  localparam logic [1:0] C_ACT = 2'd1;
  localparam logic [1:0] C_RW  = 2'd2;
  localparam logic [1:0] C_PRE = 2'd3;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_SEL   = 2'd1;
  localparam logic [1:0] ERR_STATE = 2'd2;

  if (T_RCD < 1 || T_CL < 1 || T_RP < 1 || T_RFC < 1 || T_REFI < 1) begin : g_param_check
    $error("dram_cmd_responder: all timing parameters must be >= 1");
  end

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_XFER, S_ACK, S_REL} state_t;

  state_t                  r_state, w_state_nx;
  logic [CW-1:0]           r_cnt, w_cnt_nx;
  logic [KW-1:0]           r_bit, w_bit_nx;
  logic [1:0]              r_cmd;
  logic [BW-1:0]           r_bank;
  logic [RWID-1:0]         r_row;
  logic [CLW-1:0]          r_col;
  logic                    r_rw;
  logic [1:0]              r_err_code;
  logic [DATA_WIDTH-1:0]   r_wr_word;
  logic [NUM_OF_BANKS-1:0] r_bank_open;
  logic [RWID-1:0]         r_open_row [NUM_OF_BANKS];
  logic [DATA_WIDTH-1:0]   r_mem [NUM_OF_BANKS][NUM_OF_ROWS][NUM_OF_COLS];

  logic [BW-1:0]         w_bank_idx;
  logic [RWID-1:0]       w_row_idx;
  logic [CLW-1:0]        w_col_idx;
  logic                  w_sel_err;
  logic                  w_state_err;
  logic [1:0]            w_err_code;
  logic [CW-1:0]         w_load;
  logic                  w_capture;
  logic                  w_commit;
  logic                  w_xfer_rd;
  logic [DATA_WIDTH-1:0] w_rd_word;
  logic [DATA_WIDTH-1:0] w_rd_shift;

  always_comb begin
    w_bank_idx = '0;
    w_row_idx  = '0;
    w_col_idx  = '0;
    for (int i = 0; i < NUM_OF_BANKS; i++) if (bus.bank_sel[i]) w_bank_idx = BW'(i);
    for (int i = 0; i < NUM_OF_ROWS; i++)  if (bus.row_sel[i])  w_row_idx  = RWID'(i);
    for (int i = 0; i < NUM_OF_COLS; i++)  if (bus.col_sel[i])  w_col_idx  = CLW'(i);
  end

  // Selection errors win over state errors; the bank index is only trusted when one-hot.
  always_comb begin
    w_sel_err   = 1'b0;
    w_state_err = 1'b0;
    w_load      = CW'(T_RP);
    case (bus.cmd)
      C_REF: begin
        w_state_err = |r_bank_open;
        w_load      = CW'(T_RFC);
      end
      C_ACT: begin
        w_sel_err   = !$onehot(bus.bank_sel) || !$onehot(bus.row_sel);
        w_state_err = r_bank_open[w_bank_idx];
        w_load      = CW'(T_RCD);
      end
      C_RW: begin
        w_sel_err   = !$onehot(bus.bank_sel) || !$onehot(bus.col_sel);
        w_state_err = !r_bank_open[w_bank_idx];
        w_load      = CW'(T_CL);
      end
      default: begin
        w_sel_err   = !$onehot(bus.bank_sel);
        w_load      = CW'(T_RP);
      end
    endcase
    w_err_code = w_sel_err ? ERR_SEL : (w_state_err ? ERR_STATE : ERR_NONE);
  end

  assign w_capture = (r_state == S_IDLE) && bus.cmd_req;
  assign w_commit  = (r_state == S_ACK) && (r_err_code == ERR_NONE);

  // A rejected command still passes through WAIT with a zero count so its ack lands one cycle later.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_bit_nx   = r_bit;
    case (r_state)
      S_IDLE: begin
        if (bus.cmd_req) begin
          w_state_nx = S_WAIT;
          w_cnt_nx   = (w_err_code != ERR_NONE) ? '0 : w_load;
        end
      end
      S_WAIT: begin
        if (r_cnt == '0) begin
          w_state_nx = (r_cmd == C_RW && r_err_code == ERR_NONE) ? S_XFER : S_ACK;
          w_bit_nx   = '0;
        end else begin
          w_cnt_nx = r_cnt - CW'(1);
        end
      end
      S_XFER: begin
        if (r_bit == KW'(DATA_WIDTH - 1)) begin
          w_state_nx = S_ACK;
          w_bit_nx   = '0;
        end else begin
          w_bit_nx = r_bit + KW'(1);
        end
      end
      S_ACK: w_state_nx = S_REL;
      S_REL: if (!bus.cmd_req) w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_bit       <= '0;
      r_cmd       <= C_REF;
      r_bank      <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_rw        <= 1'b0;
      r_err_code  <= ERR_NONE;
      r_wr_word   <= '0;
      r_bank_open <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_bit   <= w_bit_nx;
      if (w_capture) begin
        r_cmd      <= bus.cmd;
        r_bank     <= w_bank_idx;
        r_row      <= w_row_idx;
        r_col      <= w_col_idx;
        r_rw       <= bus.bank_rw;
        r_err_code <= w_err_code;
      end
      if (r_state == S_XFER) r_wr_word <= DATA_WIDTH'({r_wr_word, bus.data_in});
      if (w_commit && r_cmd == C_ACT) r_bank_open[r_bank] <= 1'b1;
      if (w_commit && r_cmd == C_PRE) r_bank_open[r_bank] <= 1'b0;
    end
  end

  // Array contents and latched rows survive reset; only the open flags are cleared.
  always_ff @(posedge i_clk) begin
    if (w_commit && r_cmd == C_ACT) r_open_row[r_bank] <= r_row;
    if (w_commit && r_cmd == C_RW && r_rw) r_mem[r_bank][r_open_row[r_bank]][r_col] <= r_wr_word;
  end

  assign w_rd_word  = r_mem[r_bank][r_open_row[r_bank]][r_col];
  assign w_rd_shift = w_rd_word << r_bit;
  assign w_xfer_rd  = (r_state == S_XFER) && !r_rw;

  assign bus.data_oe  = w_xfer_rd;
  assign bus.data_out = w_xfer_rd & w_rd_shift[DATA_WIDTH-1];
  assign bus.busy     = (r_state != S_IDLE);
  assign bus.cmd_ack  = (r_state == S_ACK);
  assign bus.err      = (r_state == S_ACK) && (r_err_code != ERR_NONE);
  assign bus.err_code = r_err_code;

`ifdef DRAM_RESP_REFRESH_WDT_EN
  localparam int WW = $clog2(T_REFI + 1);

  logic [WW-1:0] r_wdt_cnt;
  logic          r_refresh_miss;

  always_ff @(posedge i_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      r_wdt_cnt      <= '0;
      r_refresh_miss <= 1'b0;
    end else begin
      if (w_commit && r_cmd == C_REF) r_wdt_cnt <= '0;
      else if (r_wdt_cnt != WW'(T_REFI)) r_wdt_cnt <= r_wdt_cnt + WW'(1);
      if (r_wdt_cnt == WW'(T_REFI)) r_refresh_miss <= 1'b1;
    end
  end

  assign bus.refresh_miss = r_refresh_miss;
`else
  assign bus.refresh_miss = 1'b0;
`endif
endmodule

// File: tb/tb_dram_cmd_responder.sv
// tb/tb_dram_cmd_responder.sv - scoreboard bench for dram_cmd_responder with a behavioural array model
module tb_dram_cmd_responder;
  localparam int NB = 8, NR = 128, NC = 8, DW = 8;
  localparam int T_RCD = 3, T_CL = 2, T_RP = 3, T_RFC = 8;
`ifdef DRAM_RESP_REFRESH_WDT_EN
  localparam int   T_REFI   = 16;
  localparam logic EXP_MISS = 1'b1;
`else
  localparam int   T_REFI   = 1024;
  localparam logic EXP_MISS = 1'b0;
`endif
  localparam logic [1:0] C_REF = 2'd0, C_ACT = 2'd1, C_RW = 2'd2, C_PRE = 2'd3;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_mis = 0;

  dram_cmd_responder_if #(.NUM_OF_BANKS(NB), .NUM_OF_ROWS(NR), .NUM_OF_COLS(NC)) bus ();

  dram_cmd_responder #(
    .NUM_OF_BANKS(NB), .NUM_OF_ROWS(NR), .NUM_OF_COLS(NC), .DATA_WIDTH(DW),
    .T_RCD(T_RCD), .T_CL(T_CL), .T_RP(T_RP), .T_RFC(T_RFC), .T_REFI(T_REFI)
  ) dut (
    .i_clk  (clk),
    .i_rst_b(rst_b),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            ack_cyc;
    logic          err;
    logic [1:0]    code;
    logic          is_rd;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sb[$];
  logic [NB-1:0] m_open = '0;
  int            m_row[NB];
  logic [DW-1:0] m_mem[int];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int oh_idx(input logic [127:0] v);
    for (int i = 0; i < 128; i++) if (v[i]) return i;
    return 0;
  endfunction

  // Monitor: gathers serial read bits and checks every ack against the scoreboard head.
  int            mon_oe = 0;
  int            mon_stray = 0;
  logic [DW-1:0] mon_rd = '0;
  logic          mon_prev_ack = 1'b0;
  exp_t          mon_e;

  always @(negedge clk) begin
    if (!rst_b) begin
      mon_oe = 0; mon_stray = 0; mon_rd = '0; mon_prev_ack = 1'b0;
    end else begin
      if (bus.data_oe) begin
        mon_rd = {mon_rd[DW-2:0], bus.data_out};
        mon_oe++;
      end else if (bus.data_out) begin
        mon_stray++;
      end
      if (bus.err && !bus.cmd_ack) mon_stray++;
      if (bus.cmd_ack) begin
        chk("ack_width", mon_prev_ack, 0);
        chk("ack_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          chk("ack_cycle", cyc, mon_e.ack_cyc);
          chk("err", bus.err, mon_e.err);
          chk("err_code", bus.err_code, mon_e.code);
          chk("oe_count", mon_oe, mon_e.is_rd ? DW : 0);
          chk("rd_data", mon_rd, mon_e.data);
          chk("stray_out", mon_stray, 0);
        end
        mon_oe = 0; mon_stray = 0; mon_rd = '0;
      end
      mon_prev_ack = bus.cmd_ack;
    end
  end

  task automatic issue(input logic [1:0] c, input logic [NB-1:0] bs, input logic [NR-1:0] rs,
                       input logic [NC-1:0] cs, input logic rw, input logic [DW-1:0] wd, input int hold);
    exp_t e;
    int   b, key, e0, k, lat, busy_bad;
    logic wr, got;
    b = oh_idx(bs); wr = rw; busy_bad = 0; got = 1'b0;
    e.code = 2'd0; e.is_rd = 1'b0; e.data = '0;
    if ((c != C_REF && $countones(bs) != 1) || (c == C_ACT && $countones(rs) != 1) ||
        (c == C_RW && $countones(cs) != 1))
      e.code = 2'd1;
    else if ((c == C_ACT && m_open[b]) || (c == C_RW && !m_open[b]) || (c == C_REF && m_open != '0))
      e.code = 2'd2;
    e.err = (e.code != 2'd0);
    if (e.err) lat = 1;
    else case (c)
      C_REF:   lat = T_RFC + 1;
      C_ACT:   lat = T_RCD + 1;
      C_PRE:   lat = T_RP + 1;
      default: lat = T_CL + DW + 1;
    endcase
    if (!e.err) case (c)
      C_ACT: begin m_open[b] = 1'b1; m_row[b] = oh_idx(rs); end
      C_PRE: m_open[b] = 1'b0;
      C_RW: begin
        key = (b * NR + m_row[b]) * NC + oh_idx(cs);
        if (!wr && !m_mem.exists(key)) wr = 1'b1;
        if (wr) m_mem[key] = wd;
        else begin e.is_rd = 1'b1; e.data = m_mem[key]; end
      end
      default: ;
    endcase
    @(negedge clk);
    e0 = cyc + 1;
    e.ack_cyc = e0 + lat;
    sb.push_back(e);
    bus.cmd = c; bus.bank_sel = bs; bus.row_sel = rs; bus.col_sel = cs; bus.bank_rw = wr;
    bus.cmd_req = 1'b1;
    for (int t = 0; t < 64 && !got; t++) begin
      @(negedge clk);
      if (!bus.busy) busy_bad++;
      k = cyc - (e0 + T_CL + 1);
      bus.data_in = (k >= 0 && k < DW) ? wd[DW-1-k] : 1'($urandom);
      bus.cmd = 2'($urandom); bus.bank_sel = NB'($urandom); bus.col_sel = NC'($urandom);
      bus.row_sel = {4{$urandom}}; bus.bank_rw = 1'($urandom);
      if (bus.cmd_ack) got = 1'b1;
    end
    chk("ack_seen", got, 1);
    chk("busy_during_cmd", busy_bad, 0);
    if (!got) sb.delete();
    repeat (hold) @(negedge clk);
    bus.cmd_req = 1'b0;
    for (int t = 0; t < 8 && bus.busy; t++) @(negedge clk);
    chk("busy_release", bus.busy, 0);
  endtask

  task automatic row_oh(input int r, output logic [NR-1:0] v);
    v = '0; v[r] = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded its cycle budget");
    $fatal(1, "timeout");
  end

  initial begin
    logic [NR-1:0] rs;
    logic [NB-1:0] bs;
    logic [NC-1:0] cs;
    logic [1:0]    c;
    bus.cmd_req = 1'b0; bus.cmd = '0; bus.bank_sel = '0; bus.row_sel = '0;
    bus.col_sel = '0; bus.bank_rw = 1'b0; bus.data_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state", {bus.cmd_ack, bus.busy, bus.err, bus.err_code, bus.data_oe,
                        bus.data_out, bus.refresh_miss}, 0);
    rst_b = 1'b1;

    row_oh(5, rs);
    issue(C_ACT, 8'h04, rs, 8'h01, 1'b0, 8'h00, 0);
    issue(C_RW, 8'h04, rs, 8'h02, 1'b1, 8'hA5, 0);
    issue(C_RW, 8'h04, rs, 8'h02, 1'b0, 8'h00, 0);
    issue(C_RW, 8'h08, rs, 8'h02, 1'b0, 8'h00, 0);
    issue(C_ACT, 8'h05, rs, 8'h01, 1'b0, 8'h00, 0);
    issue(C_REF, 8'h00, rs, 8'h01, 1'b0, 8'h00, 0);
    issue(C_PRE, 8'h04, rs, 8'h01, 1'b0, 8'h00, 0);
    issue(C_REF, 8'h00, rs, 8'h01, 1'b0, 8'h00, 0);
    row_oh(3, rs);
    issue(C_ACT, 8'h02, rs, 8'h01, 1'b0, 8'h00, 5);

    for (int n = 0; n < 200; n++) begin
      c  = 2'($urandom_range(0, 3));
      bs = NB'(1) << $urandom_range(0, 3);
      if ($urandom_range(0, 9) == 0) bs = NB'($urandom);
      row_oh($urandom_range(0, 3), rs);
      if ($urandom_range(0, 14) == 0) rs = '0;
      cs = NC'(1) << $urandom_range(0, NC - 1);
      if ($urandom_range(0, 14) == 0) cs = '0;
      issue(c, bs, rs, cs, 1'($urandom), DW'($urandom),
            ($urandom_range(0, 7) == 0) ? $urandom_range(1, 4) : 0);
    end

    for (int b = 0; b < NB; b++) issue(C_PRE, NB'(1) << b, rs, cs, 1'b0, 8'h00, 0);
    row_oh(0, rs);
    issue(C_ACT, 8'h01, rs, 8'h01, 1'b0, 8'h00, 0);
    issue(C_RW, 8'h01, rs, 8'h01, 1'b1, 8'h3C, 0);
    @(negedge clk);
    bus.cmd = C_RW; bus.bank_sel = 8'h01; bus.col_sel = 8'h01; bus.bank_rw = 1'b0;
    bus.cmd_req = 1'b1;
    repeat (T_CL + 4) @(negedge clk);
    chk("abort_in_xfer", bus.data_oe, 1);
    rst_b = 1'b0;
    bus.cmd_req = 1'b0;
    #1;
    chk("reset_mid_xfer", {bus.cmd_ack, bus.busy, bus.err, bus.err_code, bus.data_oe,
                           bus.data_out, bus.refresh_miss}, 0);
    m_open = '0;
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    issue(C_RW, 8'h01, rs, 8'h01, 1'b0, 8'h00, 0);
    issue(C_ACT, 8'h01, rs, 8'h01, 1'b0, 8'h00, 0);
    issue(C_RW, 8'h01, rs, 8'h01, 1'b0, 8'h00, 0);
    issue(C_PRE, 8'h01, rs, 8'h01, 1'b0, 8'h00, 0);

    repeat (T_REFI + 4) @(negedge clk);
    chk("refresh_miss_set", bus.refresh_miss, EXP_MISS);
    issue(C_REF, 8'h00, rs, 8'h01, 1'b0, 8'h00, 0);
    chk("refresh_miss_sticky", bus.refresh_miss, EXP_MISS);

    repeat (4) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/dram_cmd_responder.md
Name: dram_cmd_responder

Overview:
- Device-side model of the DRAM array, directly downstream of the controller.
- Consumes the controller's cmd_req/cmd handshake, one-hot bank/row/col selects and bank_rw direction.
- Enforces per-command timing, tracks the open row per bank, and moves one DATA_WIDTH word serially (MSB first) per read or write.
- Answers each command with a one-cycle cmd_ack and flags protocol violations.

Parameters:
- NUM_OF_BANKS, 8: banks; bank_sel width.
- NUM_OF_ROWS, 128: rows per bank; row_sel width.
- NUM_OF_COLS, 8: columns per row; col_sel width.
- DATA_WIDTH, 8: bits per word, shifted serially.
- T_RCD, 3: ACTIVATE wait cycles (>=1).
- T_CL, 2: READ/WRITE wait cycles before the transfer (>=1).
- T_RP, 3: PRECHARGE wait cycles (>=1).
- T_RFC, 8: REFRESH wait cycles (>=1).
- T_REFI, 1024: refresh watchdog interval (optional feature only).

Ports:
- clk  in  1  clock
- rst_b  in  1  asynchronous active-low reset
- cmd_req  in  1  command request, level, held until cmd_ack
- cmd  in  2  00 REFRESH, 01 ACTIVATE, 10 READWRITE, 11 PRECHARGE
- bank_sel  in  NUM_OF_BANKS  one-hot bank
- row_sel  in  NUM_OF_ROWS  one-hot row (used by ACTIVATE only)
- col_sel  in  NUM_OF_COLS  one-hot column (used by READWRITE only)
- bank_rw  in  1  1 = write, 0 = read
- data_in  in  1  serial write data
- data_out  out  1  serial read data
- data_oe  out  1  high while data_out carries read bits
- cmd_ack  out  1  one-cycle completion pulse
- busy  out  1  high in every state except IDLE
- err  out  1  one-cycle pulse coincident with cmd_ack on a violation
- err_code  out  2  0 none, 1 SEL_ERR, 2 STATE_ERR; held until the next capture
- refresh_miss  out  1  sticky watchdog flag (optional feature)

Behaviour:
- Reset: every output is 0; all bank open flags are cleared; FSM goes to IDLE.
- Reset mid-command aborts the command with no ack. Memory contents are not reset.
- FSM states: IDLE, WAIT, XFER, ACK, REL.
- IDLE: on an edge E0 with cmd_req=1, capture cmd, bank index, row index, col index and bank_rw; go to WAIT.
- Checks at capture:
  - SEL_ERR: bank_sel not exactly one-hot for ACT/RW/PRE; row_sel not one-hot for ACT; col_sel not one-hot for RW.
  - STATE_ERR: ACT to an open bank; RW to a closed bank; REFRESH while any bank is open.
  - SEL_ERR has priority over STATE_ERR.
  - On error: skip the wait, go to ACK; cmd_ack and err are high in the cycle after E0+1; no bank, row or memory state changes.
- WAIT: counter loads T_x and decrements to 0.
  - ACT, PRE, REF: cmd_ack is high in the cycle after edge E0+T_x+1, exactly one cycle.
  - ACT sets the bank open with the captured row. PRE clears the bank's open flag. PRE to an already-closed bank is legal (no-op). REF only waits.
- XFER (READWRITE): DATA_WIDTH cycles; bit k (k=0 is the MSB) occupies the cycle after edge E0+T_CL+1+k.
  - Read: data_oe=1, data_out = mem[bank][open_row][col] bit k.
  - Write: data_in sampled at edge E0+T_CL+2+k; the word is committed to memory at the ack edge.
  - cmd_ack is high in the cycle after edge E0+T_CL+DATA_WIDTH+1.
  - data_oe and data_out are 0 outside read XFER.
- ACK → REL. REL waits for cmd_req=0 before returning to IDLE. A request held high across the ack is never re-captured; a new command needs cmd_req low for at least one cycle.
- cmd and select changes while busy are ignored; only the captured copy is used.

Optional Feature:
- DRAM_RESP_REFRESH_WDT_EN defined: a counter increments every cycle and clears on each acked legal REFRESH.
  - When the count reaches T_REFI, refresh_miss sets and stays set until reset.
  - The counter saturates at T_REFI.
- DRAM_RESP_REFRESH_WDT_EN undefined: refresh_miss is tied to 0 and no counter exists.

Test Plan:
- ACT bank_sel=8'h04, row_sel bit 5, T_RCD=3 → ack exactly one cycle after edge E0+4; busy high E0..ack; err=0.
- Then WRITE col_sel=8'h02, serial 8'hA5 → ack after edge E0+11. READ same bank/col → data_oe high 8 cycles, data_out = 1,0,1,0,0,1,0,1.
- READWRITE to bank 3 while closed → ack after edge E0+2, err=1, err_code=2, data_oe stays 0. ACT with bank_sel=8'h05 → err_code=1.
- REFRESH with bank 2 open → err_code=2. PRE bank 2, then REFRESH → ack after edge E0+T_RFC+1 = E0+9, err=0.
- Hold cmd_req high 5 cycles after ack → no second capture. Assert rst_b=0 mid-XFER → all outputs 0, bank flags cleared; a following READWRITE gives STATE_ERR.
- With DRAM_RESP_REFRESH_WDT_EN and T_REFI=16, no REFRESH for 16 cycles → refresh_miss=1 and stays set through a later legal REFRESH.
